ads_emu: RTL and testbench
==========================

ADS_EMU -- requirements
Module: ads_emu

Interface
REQ-001 Parameter CONV_CYCLES, default 100, BUSY high time in sys_clk cycles (legal 2..65535).
REQ-002 sys_clk  input  1  single block clock; every flop on its rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ADS_CLK  input  1  serial clock from ADC master; sampled, never used as a clock.
REQ-005 ADS_CS_N  input  1  frame select, active-low.
REQ-006 ADS_CONVST  input  1  conversion start, rising edge.
REQ-007 ADS_RD  input  1  read enable, sampled at frame start.
REQ-008 ADS_SDI  input  1  serial config data from master.
REQ-009 ADS_M  input  2  output mode; bit0=0 dual-lane, bit0=1 single-lane; bit1 unused.
REQ-010 CH_A_DATA, CH_B_DATA  input  16 each  sample values presented to the emulated ADC.
REQ-011 ADS_BUSY  output  1  conversion in progress.
REQ-012 ADS_SDOA, ADS_SDOB  output  1 each  serial data lanes.
REQ-013 CFG_REG  output  16  last complete SDI word; CFG_VALID  output  1  one-cycle update strobe.
REQ-014 OVR  output  1  sticky: CONVST edge arrived while BUSY.

Function
REQ-015 ADS_CLK, ADS_CS_N, ADS_CONVST each SHALL pass a 2-flop synchronizer plus edge detect; a pin edge acts on the 3rd sys_clk rising edge after it.
REQ-016 FSM states IDLE, CONV, READY, SHIFT; reset state IDLE.
REQ-017 IDLE/READY + CONVST rise: latch channel data into SAMPLE_A/SAMPLE_B, ADS_BUSY=1 next cycle, go CONV.
REQ-018 CONV: count CONV_CYCLES cycles, then ADS_BUSY=0 and go READY; CONVST rise in CONV ignored, sets OVR.
REQ-019 CS_N fall in IDLE or READY: sample ADS_RD and ADS_M[0], clear bit counter, go SHIFT; CS_N fall in CONV ignored.
REQ-020 Frame length 16 ADS_CLK rising edges dual-lane, 32 single-lane.
REQ-021 Dual-lane, RD=1: SDOA carries SAMPLE_A, SDOB SAMPLE_B, MSB first; MSB valid the cycle after SHIFT entry; next bit on each ADS_CLK falling edge.
REQ-022 Single-lane, RD=1: SDOA carries SAMPLE_A then SAMPLE_B (32 bits, MSB first); SDOB held 0.
REQ-023 RD=0: SDOA/SDOB held 0 for the whole frame; SDI capture unaffected.
REQ-024 SDI shifted in MSB first on each ADS_CLK rising edge; after 16th rising edge CFG_REG updated and CFG_VALID pulses once, even in 32-bit frames.
REQ-025 Frame complete, CS_N still low: SDO lanes 0, further ADS_CLK ignored until CS_N rise.
REQ-026 CS_N rise in SHIFT: go IDLE; if fewer than 16 rising edges seen, CFG_REG unchanged, no CFG_VALID.
REQ-027 CONVST rise during SHIFT ignored, sets OVR; SAMPLE_A/B never change mid-frame.
REQ-028 A read from IDLE without new conversion re-sends last latched samples.
REQ-029 OVR cleared only by reset.

Reset
REQ-030 While sys_rst_n low: state IDLE, ADS_BUSY 0, SDOA/SDOB 0, CFG_REG 0x0000, CFG_VALID 0, OVR 0, samples 0, counters 0, synchronizers 1 for CS_N and 0 otherwise.
REQ-031 Reset mid-conversion or mid-frame aborts immediately; no CFG_VALID generated.
REQ-032 Deassertion is synchronized internally; first edge detection possible 2 cycles after release.

Configuration
REQ-033 Macro ADS_EMU_PATTERN_EN defined: CH_A_DATA/CH_B_DATA ignored; internal 16-bit counter PAT (reset 0) latched as SAMPLE_A=PAT, SAMPLE_B=~PAT at each accepted CONVST, PAT then increments, wraps 0xFFFF->0x0000.
REQ-034 Macro undefined: samples latched from CH_A_DATA/CH_B_DATA; no pattern logic synthesized.

Verification
REQ-035 CH_A=0xA5C3, CH_B=0x0FF0, CONVST pulse, M=0, RD=1, 16 clocks -> BUSY high exactly 100 cycles; SDOA 0xA5C3, SDOB 0x0FF0.
REQ-036 Same samples, M[0]=1 -> SDOA 0xA5C30FF0 over 32 clocks, SDOB constant 0.
REQ-037 SDI 0x8123 over 16 clocks -> CFG_REG=0x8123, one CFG_VALID; repeat with CS_N raised after 9 clocks -> CFG_REG stays 0x8123, no strobe.
REQ-038 Second CONVST 20 cycles into CONV -> OVR=1, BUSY still drops at cycle 100, samples unchanged.
REQ-039 sys_rst_n pulsed low after bit 5 of a frame -> all REQ-030 values, next frame shifts 0x0000.
REQ-040 With ADS_EMU_PATTERN_EN, three conversions+reads -> SDOA 0x0000,0x0001,0x0002; SDOB 0xFFFF,0xFFFE,0xFFFD.

Source files
------------

// File: rtl/ads_emu_if.sv
// Pin bundle between an ADC master (testbench/host) and the ADS emulator.
interface ads_emu_if;
  logic        ADS_CLK;
  logic        ADS_CS_N;
  logic        ADS_CONVST;
  logic        ADS_RD;
  logic        ADS_SDI;
  logic [1:0]  ADS_M;
  logic [15:0] CH_A_DATA;
  logic [15:0] CH_B_DATA;
  logic        ADS_BUSY;
  logic        ADS_SDOA;
  logic        ADS_SDOB;
  logic [15:0] CFG_REG;
  logic        CFG_VALID;
  logic        OVR;

  modport master (
    output ADS_CLK, ADS_CS_N, ADS_CONVST, ADS_RD, ADS_SDI, ADS_M, CH_A_DATA, CH_B_DATA,
    input  ADS_BUSY, ADS_SDOA, ADS_SDOB, CFG_REG, CFG_VALID, OVR
  );

  modport slave (
    input  ADS_CLK, ADS_CS_N, ADS_CONVST, ADS_RD, ADS_SDI, ADS_M, CH_A_DATA, CH_B_DATA,
    output ADS_BUSY, ADS_SDOA, ADS_SDOB, CFG_REG, CFG_VALID, OVR
  );
endinterface

// File: rtl/ads_emu.sv
// Dual-channel serial ADC emulator: conversion timing, dual/single-lane readout, SDI config capture.
// Define ADS_EMU_PATTERN_EN to replace channel inputs with an internal counting test pattern.
module ads_emu #(
  parameter int unsigned CONV_CYCLES = 100
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  ads_emu_if.slave bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 6;
  localparam int unsigned SMP_W  = 16;
  localparam int unsigned SH_W   = 2 * SMP_W;

  typedef enum logic [1:0] {IDLE, CONV, READY, SHIFT} state_t;

  // Reset release is re-timed to sys_clk; assertion stays asynchronous.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Pin synchronizers; third stage feeds the edge detectors.
  logic [2:0] sclk_q, cs_q, cv_q;
  logic [1:0] sdi_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      cv_q   <= '0;
      sdi_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.ADS_CLK};
      cs_q   <= {cs_q[1:0], bus.ADS_CS_N};
      cv_q   <= {cv_q[1:0], bus.ADS_CONVST};
      sdi_q  <= {sdi_q[0], bus.ADS_SDI};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cv_rise, sdi_bit;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cv_rise   = cv_q[1] & ~cv_q[2];
  assign sdi_bit   = sdi_q[1];

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SMP_W-1:0]   sample_a_q, sample_a_d, sample_b_q, sample_b_d;
  logic [SH_W-1:0]    sh_a_q, sh_a_d;
  logic [SMP_W-1:0]   sh_b_q, sh_b_d;
  logic [SMP_W-1:0]   sdi_sh_q, sdi_sh_d;
  logic               rd_q, rd_d, single_q, single_d;
  logic               busy_q, busy_d, sdoa_q, sdoa_d, sdob_q, sdob_d;
  logic [SMP_W-1:0]   cfg_reg_q, cfg_reg_d;
  logic               cfg_valid_q, cfg_valid_d, ovr_q, ovr_d;
  logic [SMP_W-1:0]   new_a, new_b;
  logic [BIT_W-1:0]   frame_len;
  logic               frame_done;
  logic               unused_ok;

`ifdef ADS_EMU_PATTERN_EN
  logic [SMP_W-1:0] pat_q, pat_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  assign new_a     = pat_q;
  assign new_b     = ~pat_q;
  assign unused_ok = &{1'b0, bus.ADS_M[1], bus.CH_A_DATA, bus.CH_B_DATA};
`else
  assign new_a     = bus.CH_A_DATA;
  assign new_b     = bus.CH_B_DATA;
  assign unused_ok = &{1'b0, bus.ADS_M[1]};
`endif

  assign frame_len  = single_q ? BIT_W'(32) : BIT_W'(16);
  assign frame_done = (bit_cnt_q == frame_len);

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    conv_cnt_d  = conv_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sample_a_d  = sample_a_q;
    sample_b_d  = sample_b_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    sdi_sh_d    = sdi_sh_q;
    rd_d        = rd_q;
    single_d    = single_q;
    busy_d      = busy_q;
    sdoa_d      = sdoa_q;
    sdob_d      = sdob_q;
    cfg_reg_d   = cfg_reg_q;
    cfg_valid_d = 1'b0;
    ovr_d       = ovr_q;
`ifdef ADS_EMU_PATTERN_EN
    pat_d       = pat_q;
`endif

    case (state_q)
      IDLE, READY: begin
        if (cv_rise) begin
          sample_a_d = new_a;
          sample_b_d = new_b;
          busy_d     = 1'b1;
          conv_cnt_d = '0;
          state_d    = CONV;
`ifdef ADS_EMU_PATTERN_EN
          pat_d      = pat_q + SMP_W'(1);
`endif
        end else if (cs_fall) begin
          rd_d      = bus.ADS_RD;
          single_d  = bus.ADS_M[0];
          bit_cnt_d = '0;
          sh_a_d    = bus.ADS_M[0] ? {sample_a_q, sample_b_q} : {sample_a_q, SMP_W'(0)};
          sh_b_d    = sample_b_q;
          sdoa_d    = bus.ADS_RD & sample_a_q[SMP_W-1];
          sdob_d    = bus.ADS_RD & ~bus.ADS_M[0] & sample_b_q[SMP_W-1];
          state_d   = SHIFT;
        end
      end

      CONV: begin
        if (cv_rise) ovr_d = 1'b1;
        if (conv_cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = READY;
        end else begin
          conv_cnt_d = conv_cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (cv_rise) ovr_d = 1'b1;
        if (cs_rise) begin
          sdoa_d  = 1'b0;
          sdob_d  = 1'b0;
          state_d = IDLE;
        end else if (!frame_done) begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q < BIT_W'(16)) sdi_sh_d = {sdi_sh_q[SMP_W-2:0], sdi_bit};
            if (bit_cnt_q == BIT_W'(15)) begin
              cfg_reg_d   = {sdi_sh_q[SMP_W-2:0], sdi_bit};
              cfg_valid_d = 1'b1;
            end
            // Lanes go quiet as soon as the last bit has been clocked out.
            if (bit_cnt_q == frame_len - BIT_W'(1)) begin
              sdoa_d = 1'b0;
              sdob_d = 1'b0;
            end
          end else if (sclk_fall && (bit_cnt_q != '0)) begin
            sh_a_d = {sh_a_q[SH_W-2:0], 1'b0};
            sh_b_d = {sh_b_q[SMP_W-2:0], 1'b0};
            sdoa_d = rd_q & sh_a_q[SH_W-2];
            sdob_d = rd_q & ~single_q & sh_b_q[SMP_W-2];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      conv_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      sample_a_q  <= '0;
      sample_b_q  <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      sdi_sh_q    <= '0;
      rd_q        <= 1'b0;
      single_q    <= 1'b0;
      busy_q      <= 1'b0;
      sdoa_q      <= 1'b0;
      sdob_q      <= 1'b0;
      cfg_reg_q   <= '0;
      cfg_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      conv_cnt_q  <= conv_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sample_a_q  <= sample_a_d;
      sample_b_q  <= sample_b_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      sdi_sh_q    <= sdi_sh_d;
      rd_q        <= rd_d;
      single_q    <= single_d;
      busy_q      <= busy_d;
      sdoa_q      <= sdoa_d;
      sdob_q      <= sdob_d;
      cfg_reg_q   <= cfg_reg_d;
      cfg_valid_q <= cfg_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.ADS_BUSY  = busy_q;
  assign bus.ADS_SDOA  = sdoa_q;
  assign bus.ADS_SDOB  = sdob_q;
  assign bus.CFG_REG   = cfg_reg_q;
  assign bus.CFG_VALID = cfg_valid_q;
  assign bus.OVR       = ovr_q;

endmodule

// File: tb/tb_ads_emu.sv
// Self-checking bench for ads_emu: table of conversion/read vectors plus hand-built corner sequences.
module tb_ads_emu;
  localparam int CONV = 100;
  localparam int HALF = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ads_emu_if bus();
  ads_emu #(.CONV_CYCLES(CONV)) dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [15:0] ch_a;
    logic [15:0] ch_b;
    bit          m0;
    bit          rd;
    logic [15:0] sdi;
    int          extra;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [15:0] exp_cfg;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } sdo_exp_t;

  vec_t        vecs [6];
  sdo_exp_t    sb_q [$];
  logic [15:0] cfg_q [$];
  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          n_strobe = 0;
  logic [15:0] smp_a = '0, smp_b = '0, pat_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected sample latch behaviour of the emulated ADC.
  task automatic model_conv(input logic [15:0] a, input logic [15:0] b);
`ifdef ADS_EMU_PATTERN_EN
    smp_a = pat_m;
    smp_b = ~pat_m;
    pat_m = pat_m + 16'd1;
`else
    smp_a = a;
    smp_b = b;
`endif
  endtask

  function automatic logic [31:0] exp_a_f(input bit m0, input bit rd);
    if (!rd)   return 32'd0;
    if (m0)    return {smp_a, smp_b};
    return {16'd0, smp_a};
  endfunction

  function automatic logic [31:0] exp_b_f(input bit m0, input bit rd);
    if (!rd || m0) return 32'd0;
    return {16'd0, smp_b};
  endfunction

  // Every CFG_VALID strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (bus.CFG_VALID === 1'b1) begin
      n_strobe++;
      if (cfg_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cfg_strobe: unexpected strobe with CFG_REG %h, want none", bus.CFG_REG);
      end else begin
        chk("cfg_reg", 32'(bus.CFG_REG), 32'(cfg_q.pop_front()));
      end
    end
  end

  // CONVST pulse, then measure BUSY width; optionally a second CONVST at cycle ovr_at.
  task automatic conv(input logic [15:0] a, input logic [15:0] b, input int ovr_at, output int len);
    int w;
    w   = 0;
    len = 0;
    bus.CH_A_DATA  = a;
    bus.CH_B_DATA  = b;
    bus.ADS_CONVST = 1'b1;
    while (bus.ADS_BUSY !== 1'b1 && w < 20) begin
      tick(1);
      w++;
    end
    bus.ADS_CONVST = 1'b0;
    if (bus.ADS_BUSY !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_rise: BUSY is %b after 20 cycles, want 1", bus.ADS_BUSY);
      return;
    end
    model_conv(a, b);
    while (bus.ADS_BUSY === 1'b1 && len < 1000) begin
      len++;
      if (len == ovr_at) begin
        bus.ADS_CONVST = 1'b1;
        bus.CH_A_DATA  = ~a;
        bus.CH_B_DATA  = ~b;
      end
      if (len == ovr_at + 4) bus.ADS_CONVST = 1'b0;
      tick(1);
    end
  endtask

  // One master frame; expectations go to the scoreboard before the frame starts.
  task automatic frame(input int nclk, input bit m0, input bit rd, input logic [15:0] sdi,
                       input bit chk_sdo, input logic [31:0] ea, input logic [31:0] eb,
                       input bit push_cfg, input logic [15:0] ecfg, input bit raise, input int cv_at);
    logic [31:0] ca;
    logic [31:0] cb;
    logic [15:0] s;
    int          flen;
    ca   = '0;
    cb   = '0;
    s    = sdi;
    flen = m0 ? 32 : 16;
    bus.ADS_M  = {1'b0, m0};
    bus.ADS_RD = rd;
    if (push_cfg) cfg_q.push_back(ecfg);
    if (chk_sdo)  sb_q.push_back('{ea, eb});
    bus.ADS_CS_N = 1'b0;
    for (int i = 0; i < nclk; i++) begin
      bus.ADS_SDI = s[15];
      s = s << 1;
      if (i == cv_at)     bus.ADS_CONVST = 1'b1;
      if (i == cv_at + 2) bus.ADS_CONVST = 1'b0;
      tick(HALF);
      if (i < flen) begin
        ca = {ca[30:0], bus.ADS_SDOA};
        cb = {cb[30:0], bus.ADS_SDOB};
      end else begin
        chk("sdo_after_frame", 32'({bus.ADS_SDOA, bus.ADS_SDOB}), 32'd0);
      end
      bus.ADS_CLK = 1'b1;
      tick(HALF);
      bus.ADS_CLK = 1'b0;
    end
    bus.ADS_CONVST = 1'b0;
    tick(HALF);
    if (raise) begin
      bus.ADS_CS_N = 1'b1;
      tick(HALF);
    end
    if (chk_sdo) begin
      sdo_exp_t e;
      e = sb_q.pop_front();
      chk("sdoa_word", ca, e.a);
      chk("sdob_word", cb, e.b);
    end
  endtask

  initial begin
    int          len;
    int          ns;
    logic [31:0] ea;
    logic [31:0] eb;

    bus.ADS_CLK    = 1'b0;
    bus.ADS_CS_N   = 1'b1;
    bus.ADS_CONVST = 1'b0;
    bus.ADS_RD     = 1'b0;
    bus.ADS_SDI    = 1'b0;
    bus.ADS_M      = 2'b00;
    bus.CH_A_DATA  = '0;
    bus.CH_B_DATA  = '0;

    vecs[0] = '{16'hA5C3, 16'h0FF0, 1'b0, 1'b1, 16'h8123, 0, 32'h0000A5C3, 32'h00000FF0, 16'h8123};
    vecs[1] = '{16'hA5C3, 16'h0FF0, 1'b1, 1'b1, 16'h1234, 0, 32'hA5C30FF0, 32'h00000000, 16'h1234};
    vecs[2] = '{16'h1234, 16'hFEDC, 1'b0, 1'b0, 16'hFFFF, 0, 32'h00000000, 32'h00000000, 16'hFFFF};
    vecs[3] = '{16'h8001, 16'h7FFE, 1'b1, 1'b0, 16'h0000, 0, 32'h00000000, 32'h00000000, 16'h0000};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 4, 32'h0000FFFF, 32'h00000000, 16'hA5A5};
    vecs[5] = '{16'h0001, 16'h8000, 1'b1, 1'b1, 16'h5A5A, 0, 32'h00018000, 32'h00000000, 16'h5A5A};

    tick(3);
    chk("rst_busy",      32'(bus.ADS_BUSY),  32'd0);
    chk("rst_sdoa_sdob", 32'({bus.ADS_SDOA, bus.ADS_SDOB}), 32'd0);
    chk("rst_cfg_reg",   32'(bus.CFG_REG),   32'd0);
    chk("rst_ovr",       32'(bus.OVR),       32'd0);
    rst_n = 1'b1;
    tick(5);

    // Table: conversion then readout in each lane mode / RD setting.
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      conv(v.ch_a, v.ch_b, 0, len);
      chk("busy_len", 32'(len), 32'(CONV));
      ea = v.exp_a;
      eb = v.exp_b;
`ifdef ADS_EMU_PATTERN_EN
      ea = exp_a_f(v.m0, v.rd);
      eb = exp_b_f(v.m0, v.rd);
`endif
      ns = n_strobe;
      frame((v.m0 ? 32 : 16) + v.extra, v.m0, v.rd, v.sdi, 1'b1, ea, eb, 1'b1, v.exp_cfg, 1'b1, -1);
      tick(2);
      chk("cfg_strobe_count", 32'(n_strobe - ns), 32'd1);
    end

    // Re-read from IDLE without a new conversion, carrying config 0x8123.
    frame(16, 1'b0, 1'b1, 16'h8123, 1'b1, exp_a_f(1'b0, 1'b1), exp_b_f(1'b0, 1'b1),
          1'b1, 16'h8123, 1'b1, -1);

    // Aborted config frame after 9 clocks leaves CFG_REG alone.
    ns = n_strobe;
    frame(9, 1'b0, 1'b1, 16'hFFFF, 1'b0, 32'd0, 32'd0, 1'b0, 16'h0000, 1'b1, -1);
    tick(2);
    chk("cfg_after_partial", 32'(bus.CFG_REG), 32'h8123);
    chk("partial_strobe",    32'(n_strobe - ns), 32'd0);

    // Second CONVST 20 cycles into a conversion.
    chk("ovr_before", 32'(bus.OVR), 32'd0);
    conv(16'h1357, 16'h2468, 20, len);
    chk("busy_len_ovr", 32'(len), 32'(CONV));
    chk("ovr_set_conv", 32'(bus.OVR), 32'd1);
    frame(16, 1'b0, 1'b1, 16'h4242, 1'b1, exp_a_f(1'b0, 1'b1), exp_b_f(1'b0, 1'b1),
          1'b1, 16'h4242, 1'b1, -1);

    // Reset pulse after bit 5 of a frame.
    ns = n_strobe;
    frame(5, 1'b0, 1'b1, 16'hBEEF, 1'b0, 32'd0, 32'd0, 1'b0, 16'h0000, 1'b0, -1);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_busy",      32'(bus.ADS_BUSY),  32'd0);
    chk("midrst_sdoa_sdob", 32'({bus.ADS_SDOA, bus.ADS_SDOB}), 32'd0);
    chk("midrst_cfg_reg",   32'(bus.CFG_REG),   32'd0);
    chk("midrst_cfg_valid", 32'(bus.CFG_VALID), 32'd0);
    chk("midrst_ovr",       32'(bus.OVR),       32'd0);
    bus.ADS_CS_N = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    smp_a = '0;
    smp_b = '0;
    pat_m = '0;
    chk("midrst_strobe", 32'(n_strobe - ns), 32'd0);
    frame(16, 1'b0, 1'b1, 16'h3C3C, 1'b1, 32'd0, 32'd0, 1'b1, 16'h3C3C, 1'b1, -1);

    // CONVST during a single-lane frame is ignored but flagged.
    conv(16'hC001, 16'h00C3, 0, len);
    chk("busy_len_last", 32'(len), 32'(CONV));
    frame(32, 1'b1, 1'b1, 16'h7E7E, 1'b1, exp_a_f(1'b1, 1'b1), exp_b_f(1'b1, 1'b1),
          1'b1, 16'h7E7E, 1'b1, 3);
    chk("ovr_set_shift",   32'(bus.OVR),      32'd1);
    chk("busy_after_shift", 32'(bus.ADS_BUSY), 32'd0);

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
